// File: rtl/axi_fifo_pkg.sv
// Shared constants and types for the axi_fifo elastic buffer.
// Imported by the interface, pointer counter and top.
package axi_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/axi_fifo_if.sv
// Write and read stream handshakes of the FIFO.
// The master side is the producer/consumer pair, the slave side is the FIFO.
interface axi_fifo_if
    import axi_fifo_pkg::*;
#(
    parameter int DW = DEF_DATA_W
) ();

    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          rready;

    modport master (
        output wdata,
        output wvalid,
        input  wready,
        input  rvalid,
        input  rdata,
        output rready
    );

    modport slave (
        input  wdata,
        input  wvalid,
        output wready,
        output rvalid,
        output rdata,
        input  rready
    );

endinterface

// File: rtl/axi_fifo_ptr.sv
// Wrapping pointer counter with increment enable and async clear.
// Carries one extra MSB so full and empty can be told apart.
module axi_fifo_ptr
    import axi_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n_i) begin
        if (!clr_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/axi_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Storage, flags and handshake firing live here; pointers are sub-modules.
module axi_fifo
    import axi_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    axi_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              wr_fire;
    logic              rd_fire;
    logic              init_q;
    logic              init_d;

    axi_fifo_ptr #(.W(ADDR_W + 1)) u_wptr (
        .clk     (clk),
        .clr_n_i (reset),
        .inc_i   (wr_fire),
        .ptr_o   (wptr)
    );

    axi_fifo_ptr #(.W(ADDR_W + 1)) u_rptr (
        .clk     (clk),
        .clr_n_i (reset),
        .inc_i   (rd_fire),
        .ptr_o   (rptr)
    );

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0])
                && (wptr[ADDR_W] != rptr[ADDR_W]);

    // Holds wready low through reset and until the first edge after release.
    assign init_d = 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end

    assign bus.wready = init_q && !full;
    assign bus.rvalid = !empty;
    assign bus.rdata  = empty ? '0 : mem_q[rptr[ADDR_W-1:0]];

    assign wr_fire = bus.wvalid && bus.wready;
    assign rd_fire = bus.rvalid && bus.rready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr[ADDR_W-1:0]] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_axi_fifo.sv
// Directed self-checking bench for axi_fifo.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axi_fifo;
    import axi_fifo_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   fails;

    axi_fifo_if #(.DW(8)) bus ();

    axi_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.wvalid = 1'b0;
        bus.wdata  = '0;
        bus.rready = 1'b0;
        step();
        step();
        tests_run++;
        if (bus.wready !== 1'b0) begin
            fails++;
            $display("FAIL rst_wready got %b exp 0", bus.wready);
        end
        tests_run++;
        if (bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rst_rvalid got %b exp 0", bus.rvalid);
        end
        tests_run++;
        if (bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL rst_rdata got %h exp 00", bus.rdata);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.wready !== 1'b1) begin
            fails++;
            $display("FAIL rel_wready got %b exp 1", bus.wready);
        end
        tests_run++;
        if (bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rel_rvalid got %b exp 0", bus.rvalid);
        end
    endtask

    task automatic test_write10();
        data_t v [10];
        v = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D,
              8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
        bus.rready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = v[i];
            step();
            tests_run++;
            if (bus.wready !== 1'b1 || bus.rvalid !== 1'b1
                || bus.rdata !== 8'h24) begin
                fails++;
                $display("FAIL wr10_%0d got wr=%b rv=%b d=%h exp 1 1 24",
                         i, bus.wready, bus.rvalid, bus.rdata);
            end
        end
        bus.wvalid = 1'b0;
    endtask

    task automatic test_read3();
        data_t e [3];
        e = '{8'h24, 8'h81, 8'h09};
        for (int k = 0; k < 3; k++) begin
            bus.rready = 1'b1;
            tests_run++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== e[k]) begin
                fails++;
                $display("FAIL rd3_%0d got rv=%b d=%h exp 1 %h",
                         k, bus.rvalid, bus.rdata, e[k]);
            end
            step();
            bus.rready = 1'b0;
            step();
        end
        tests_run++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h63) begin
            fails++;
            $display("FAIL rd3_head got rv=%b d=%h exp 1 63",
                     bus.rvalid, bus.rdata);
        end
        tests_run++;
        if (dut.count !== 5'd7) begin
            fails++;
            $display("FAIL rd3_count got %0d exp 7", dut.count);
        end
    endtask

    task automatic test_full();
        data_t e [16];
        e = '{8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D,
              8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
              8'h37, 8'h38};
        for (int i = 0; i < 9; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'(8'h30 + i);
            step();
            tests_run++;
            if (bus.wready !== (i < 8)) begin
                fails++;
                $display("FAIL fill_%0d got wready=%b exp %b",
                         i, bus.wready, (i < 8));
            end
        end
        bus.wdata = 8'hEE;
        step();
        step();
        tests_run++;
        if (bus.wready !== 1'b0 || dut.count !== 5'd16) begin
            fails++;
            $display("FAIL full_hold got wr=%b cnt=%0d exp 0 16",
                     bus.wready, dut.count);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        tests_run++;
        if (bus.wready !== 1'b1 || dut.count !== 5'd15
            || bus.rdata !== 8'h0D) begin
            fails++;
            $display("FAIL full_rd got wr=%b cnt=%0d d=%h exp 1 15 0d",
                     bus.wready, dut.count, bus.rdata);
        end
        step();
        bus.wvalid = 1'b0;
        tests_run++;
        if (bus.wready !== 1'b0 || dut.count !== 5'd16) begin
            fails++;
            $display("FAIL full_held got wr=%b cnt=%0d exp 0 16",
                     bus.wready, dut.count);
        end
        for (int k = 1; k < 17; k++) begin
            data_t x;
            x = (k == 16) ? 8'hEE : e[k];
            bus.rready = 1'b1;
            tests_run++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== x) begin
                fails++;
                $display("FAIL drain_%0d got rv=%b d=%h exp 1 %h",
                         k, bus.rvalid, bus.rdata, x);
            end
            step();
        end
        bus.rready = 1'b0;
        tests_run++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL drain_empty got rv=%b d=%h exp 0 00",
                     bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_stream();
        int got;
        got = 0;
        for (int c = 0; c < 60 && got < 40; c++) begin
            bus.wvalid = (c < 40);
            bus.wdata  = 8'(c);
            bus.rready = 1'b1;
            if (bus.rvalid) begin
                tests_run++;
                if (bus.rdata !== 8'(got)) begin
                    fails++;
                    $display("FAIL stream_%0d got %h exp %h",
                             got, bus.rdata, 8'(got));
                end
                got++;
            end
            step();
        end
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
        tests_run++;
        if (got !== 40 || bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end got n=%0d rv=%b exp 40 0",
                     got, bus.rvalid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'(8'h50 + i);
            step();
        end
        bus.wvalid = 1'b0;
        tests_run++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h50) begin
            fails++;
            $display("FAIL ar_pre got rv=%b d=%h exp 1 50",
                     bus.rvalid, bus.rdata);
        end
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.wready !== 1'b0 || bus.rvalid !== 1'b0
            || bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL ar_now got wr=%b rv=%b d=%h exp 0 0 00",
                     bus.wready, bus.rvalid, bus.rdata);
        end
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.wready !== 1'b1 || bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL ar_rel got wr=%b rv=%b exp 1 0",
                     bus.wready, bus.rvalid);
        end
        bus.wvalid = 1'b1;
        bus.wdata  = 8'hAA;
        step();
        bus.wvalid = 1'b0;
        tests_run++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'hAA) begin
            fails++;
            $display("FAIL ar_aa got rv=%b d=%h exp 1 aa",
                     bus.rvalid, bus.rdata);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        tests_run++;
        if (bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL ar_empty got rv=%b exp 0", bus.rvalid);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_write10();
        test_read3();
        test_full();
        test_stream();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/axi_fifo.md
Name: axi_fifo

Overview:
- Synchronous single-clock FIFO with AXI-stream-style valid/ready handshakes on both sides.
- Write side accepts bytes from a producer; read side presents them in order to a consumer.
- Reads are first-word-fall-through.
- Used as an elastic buffer between AXI data channels, e.g. in front of the ALU datapath.

Parameters:
- DATA_W, 8, width of wdata/rdata in bits.
- DEPTH, 16, number of storage entries; must be a power of two, ≥2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wdata  input  DATA_W  write data.
- wvalid  input  1  producer has valid wdata.
- wready  output  1  FIFO can accept a word this cycle.
- rvalid  output  1  rdata holds a valid head-of-FIFO word.
- rdata  output  DATA_W  head-of-FIFO data.
- rready  input  1  consumer accepts rdata this cycle.

Behaviour:
- Storage and pointers:
  - Register array mem[DEPTH].
  - Write pointer wptr and read pointer rptr, each ADDR_W+1 bits; the extra MSB distinguishes full from empty.
  - count = wptr - rptr (ADDR_W+1 bits).
  - empty when wptr == rptr; full when the pointer LSBs are equal and the MSBs differ.
- Reset (reset == 0, asynchronous):
  - wptr, rptr and count cleared.
  - wready = 0 while reset is asserted; wready = 1 from the first cycle after release.
  - rvalid = 0; rdata = 0.
  - mem contents are not reset.
- Write handshake:
  - wready = !full, combinational from registered state.
  - wready does not depend on rready: no write is accepted into a full FIFO even if a read occurs in the same cycle.
  - Write fires on a rising clk when wvalid && wready: mem[wptr[ADDR_W-1:0]] <= wdata; wptr increments.
  - wdata is don't-care when wvalid is 0.
- Read handshake:
  - rvalid = !empty.
  - rdata = mem[rptr[ADDR_W-1:0]] when rvalid = 1; rdata = 0 when empty.
  - Read fires on a rising clk when rvalid && rready: rptr increments.
  - The next word (if any) appears on rdata in the same cycle that follows.
  - rready while empty has no effect.
- Latency:
  - A word written at edge N is visible (rvalid = 1) after edge N.
  - There is no same-cycle bypass from wdata to rdata when empty.
- Simultaneous write and read (not full, not empty): both fire; count is unchanged.
- Stability:
  - While rvalid = 1 and rready = 0, rdata stays constant.
  - Writes never alter the head entry.
- Wrap-around: pointers roll over modulo 2·DEPTH; ordering is preserved across the wrap.
- Reset mid-operation: all buffered data is discarded immediately and asynchronously; the FIFO reads as empty after release.
- Overflow and underflow are impossible by construction: writes with wready = 0 and reads with rvalid = 0 are ignored.

Decomposition:
- Shared package axi_fifo_pkg:
  - DATA_W default constant.
  - DEPTH default constant.
  - A typedef for the data word.
- Optional sub-module fifo_ptr: one pointer counter with an increment enable and async active-low clear, instantiated twice (write and read).
- Storage and flag logic stay in axi_fifo.

Test Plan:
- Reset then idle:
  - reset = 0 for 2 cycles, then released.
  - During reset: wready = 0, rvalid = 0, rdata = 0.
  - One cycle after release: wready = 1, rvalid = 0.
- Write 10 words with rready = 0 (0x24, 0x81, 0x09, 0x63, 0x0D, 0x8D, 0x65, 0x12, 0x01, 0x0D):
  - rvalid rises after the first write, with rdata = 0x24.
  - wready stays 1 and rdata stays 0x24.
- Continuing from the previous scenario, pulse rready for 3 handshakes:
  - Consumer receives 0x24, 0x81, 0x09 in order.
  - rdata then shows 0x63 with rvalid = 1; count = 7.
- Fill to DEPTH = 16 words:
  - wready drops to 0 after the 16th write.
  - A 17th word held with wvalid = 1 is not accepted.
  - After one read, wready = 1 and the held word is written on the next edge.
- Continuous streaming with wvalid = rready = 1 for 40 cycles, data 0..39:
  - Output sequence is 0..39 with no loss or duplication across the pointer wrap.
- Async reset with 5 words buffered:
  - wready and rvalid drop immediately.
  - After release rvalid = 0; a new write of 0xAA is read back as 0xAA.
